// File: rtl/lut_table_ctrl_if.sv
// rtl/lut_table_ctrl_if.sv - lookup request/response bus for lut_table_ctrl
// Ports (modports):
//   master : requester side, drives req_valid/req_key/rsp_ready
//   slave  : table side, drives req_ready/rsp_valid/rsp_data/rsp_hit
interface lut_table_ctrl_if #(
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [KEY_LEN-1:0]  req_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN-1:0] rsp_data;
    logic                rsp_hit;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit
    );
endinterface

// File: rtl/lut_table_ctrl.sv
// rtl/lut_table_ctrl.sv - programmable key->data lookup table with handshaked lookups
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   cfg_we/cfg_idx/cfg_key/cfg_data   entry write (IDLE only)
//   cfg_clr, cfg_busy                 start / status of valid-bit clear sweep
//   default_out                       data returned on a miss when HAS_DEFAULT=1
//   bus (slave)                       req_valid/req_ready/req_key,
//                                     rsp_valid/rsp_ready/rsp_data/rsp_hit
module lut_table_ctrl #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 1,
    localparam int IDX_W      = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [KEY_LEN-1:0]  cfg_key,
    input  logic [DATA_LEN-1:0] cfg_data,
    input  logic                cfg_clr,
    output logic                cfg_busy,
    input  logic [DATA_LEN-1:0] default_out,
    lut_table_ctrl_if.slave     bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);
    localparam logic [IDX_W:0]   NR_KEY_W = (IDX_W + 1)'(NR_KEY);

    typedef enum logic {ST_IDLE, ST_CLR} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    clr_ptr_q;
    logic [NR_KEY-1:0]   valid_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    logic                rsp_valid_q;
    logic [DATA_LEN-1:0] rsp_data_q;
    logic                rsp_hit_q;

    logic                accept;
    logic                wr_en;
    logic                hit_any;
    logic [DATA_LEN-1:0] hit_data;

    // Clear has priority over a same-cycle write; out-of-range indices drop.
    assign wr_en    = (state_q == ST_IDLE) && cfg_we && !cfg_clr &&
                      ({1'b0, cfg_idx} < NR_KEY_W);
    assign cfg_busy = (state_q == ST_CLR);

    // A new request is taken only when the output slot is free or being
    // drained this cycle, giving one lookup per cycle at full throughput.
    assign bus.req_ready = (state_q == ST_IDLE) && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_hit   = rsp_hit_q;

    // Compare-OR select: every matching valid entry contributes its data.
    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (valid_q[i] && (key_q[i] == bus.req_key)) begin
                hit_any  = 1'b1;
                hit_data = hit_data | data_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_clr) state_d = ST_CLR;
            ST_CLR:  if (clr_ptr_q == LAST_IDX) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_ptr_q <= '0;
        end else if (state_q == ST_CLR) begin
            clr_ptr_q <= (clr_ptr_q == LAST_IDX) ? '0 : clr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (state_q == ST_CLR) begin
            valid_q[clr_ptr_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[cfg_idx] <= 1'b1;
        end
    end

    // Key/data storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q[cfg_idx]  <= cfg_key;
            data_q[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= hit_any;
            if (hit_any) begin
                rsp_data_q <= hit_data;
            end else begin
                rsp_data_q <= (HAS_DEFAULT != 0) ? default_out : '0;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lut_table_ctrl.sv
// tb/tb_lut_table_ctrl.sv - self-checking bench for lut_table_ctrl
module tb_lut_table_ctrl;
    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 7;
    localparam int DATA_LEN = 32;
    localparam int IDX_W    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [KEY_LEN-1:0]  cfg_key;
    logic [DATA_LEN-1:0] cfg_data;
    logic                cfg_clr;
    logic                cfg_busy;
    logic                cfg_busy0;
    logic [DATA_LEN-1:0] default_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lut_table_ctrl_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) ifc ();
    lut_table_ctrl_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) if0 ();

    assign if0.req_valid = ifc.req_valid;
    assign if0.req_key   = ifc.req_key;
    assign if0.rsp_ready = ifc.rsp_ready;

    lut_table_ctrl #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
        .cfg_data(cfg_data), .cfg_clr(cfg_clr), .cfg_busy(cfg_busy),
        .default_out(default_out), .bus(ifc.slave)
    );

    lut_table_ctrl #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
        .cfg_data(cfg_data), .cfg_clr(cfg_clr), .cfg_busy(cfg_busy0),
        .default_out(default_out), .bus(if0.slave)
    );

    // Reference model: table contents, remaining sweep cycles, pending response.
    logic [KEY_LEN-1:0]  m_key  [NR_KEY];
    logic [DATA_LEN-1:0] m_data [NR_KEY];
    bit                  m_vld  [NR_KEY];
    int                  m_busy;
    bit                  m_rv;
    bit                  m_hit;
    logic [DATA_LEN-1:0] m_rdata;
    logic [DATA_LEN-1:0] m_rdata0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NR_KEY; i++) m_vld[i] = 1'b0;
        m_busy   = 0;
        m_rv     = 1'b0;
        m_hit    = 1'b0;
        m_rdata  = '0;
        m_rdata0 = '0;
    endtask

    task automatic set_idle();
        cfg_we = 0; cfg_idx = '0; cfg_key = '0; cfg_data = '0; cfg_clr = 0;
        ifc.req_valid = 0; ifc.req_key = '0; ifc.rsp_ready = 1;
    endtask

    // Check outputs mid-cycle, then advance the model across the next edge.
    task automatic tick();
        bit                  exp_ready;
        bit                  hit;
        logic [DATA_LEN-1:0] hdata;
        @(negedge clk);
        exp_ready = (m_busy == 0) && (!m_rv || ifc.rsp_ready);
        check("req_ready", ifc.req_ready, exp_ready);
        check("cfg_busy", cfg_busy, m_busy != 0);
        check("rsp_valid", ifc.rsp_valid, m_rv);
        check("rsp_hit", ifc.rsp_hit, m_hit);
        check("rsp_data", ifc.rsp_data, m_rdata);
        check("rsp_valid_nodef", if0.rsp_valid, m_rv);
        check("rsp_data_nodef", if0.rsp_data, m_rdata0);
        if (!rst_n) begin
            m_reset();
        end else begin
            if (ifc.req_valid && exp_ready) begin
                hit = 0; hdata = '0;
                for (int i = 0; i < NR_KEY; i++)
                    if (m_vld[i] && m_key[i] == ifc.req_key) begin
                        hit = 1; hdata |= m_data[i];
                    end
                m_rv     = 1;
                m_hit    = hit;
                m_rdata  = hit ? hdata : default_out;
                m_rdata0 = hit ? hdata : '0;
            end else if (ifc.rsp_ready) begin
                m_rv = 0;
            end
            if (m_busy > 0) begin
                m_vld[NR_KEY - m_busy] = 0;
                m_busy--;
            end else if (cfg_clr) begin
                m_busy = NR_KEY;
            end else if (cfg_we && int'(cfg_idx) < NR_KEY) begin
                m_vld[cfg_idx]  = 1;
                m_key[cfg_idx]  = cfg_key;
                m_data[cfg_idx] = cfg_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d);
        cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_key = k; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic lookup(input logic [KEY_LEN-1:0] k);
        ifc.req_valid = 1; ifc.req_key = k;
        tick();
        ifc.req_valid = 0;
    endtask

    initial begin
        set_idle();
        default_out = 32'hDEADBEEF;
        rst_n = 0;
        @(posedge clk); #1;
        m_reset();
        check("reset_rsp_valid", ifc.rsp_valid, 0);
        check("reset_rsp_data", ifc.rsp_data, 0);
        check("reset_busy", cfg_busy, 0);
        rst_n = 1;

        // 1: miss returns default_out (and 0 in the no-default build)
        lookup(7'h13);
        check("t1_valid", ifc.rsp_valid, 1);
        check("t1_hit", ifc.rsp_hit, 0);
        check("t1_data", ifc.rsp_data, 32'hDEADBEEF);
        check("t1_data_nodef", if0.rsp_data, 0);

        // 2: single entry hit and neighbouring miss
        cfg_write(2, 7'h33, 32'h1234);
        lookup(7'h33);
        check("t2_hit", ifc.rsp_hit, 1);
        check("t2_data", ifc.rsp_data, 32'h1234);
        lookup(7'h34);
        check("t2_miss", ifc.rsp_hit, 0);

        // 3: back-to-back requests with a stalled consumer
        cfg_write(0, 7'h10, 32'hA0);
        cfg_write(1, 7'h11, 32'hA1);
        cfg_write(3, 7'h12, 32'hA2);
        ifc.req_valid = 1; ifc.req_key = 7'h10; ifc.rsp_ready = 1;
        tick();
        ifc.req_key = 7'h11; ifc.rsp_ready = 0;
        repeat (3) tick();
        check("t3_held", ifc.rsp_data, 32'hA0);
        ifc.rsp_ready = 1;
        tick();
        check("t3_second", ifc.rsp_data, 32'hA1);
        ifc.req_key = 7'h12; tick();
        ifc.req_key = 7'h33; tick();
        check("t3_fourth", ifc.rsp_data, 32'h1234);
        ifc.req_valid = 0;
        tick();

        // 4: clear sweep with writes/requests attempted during it
        cfg_clr = 1; tick(); cfg_clr = 0;
        cfg_we = 1; cfg_idx = 1; cfg_key = 7'h40; cfg_data = 32'h77;
        ifc.req_valid = 1; ifc.req_key = 7'h10;
        for (int i = 0; i < NR_KEY; i++) begin
            check("t4_busy", cfg_busy, 1);
            tick();
        end
        cfg_we = 0; ifc.req_valid = 0;
        check("t4_done", cfg_busy, 0);
        foreach (m_key[i]) begin
            lookup(m_key[i]);
            check("t4_miss", ifc.rsp_hit, 0);
        end
        lookup(7'h40);
        check("t4_sweep_write", ifc.rsp_hit, 0);

        // 5: same-cycle write invisible, then visible; multi-hit ORs data
        cfg_we = 1; cfg_idx = 0; cfg_key = 7'h55; cfg_data = 32'hA5;
        lookup(7'h55);
        cfg_we = 0;
        check("t5_same_cycle", ifc.rsp_hit, 0);
        lookup(7'h55);
        check("t5_hit", ifc.rsp_data, 32'hA5);
        cfg_write(1, 7'h55, 32'h5A);
        lookup(7'h55);
        check("t5_or", ifc.rsp_data, 32'hFF);

        // 6: reset during a pending response and sweep
        ifc.rsp_ready = 0;
        lookup(7'h55);
        cfg_clr = 1; tick(); cfg_clr = 0;
        tick();
        rst_n = 0; tick(); rst_n = 1;
        check("t6_valid", ifc.rsp_valid, 0);
        check("t6_busy", cfg_busy, 0);
        check("t6_ready", ifc.req_ready, 1);
        ifc.rsp_ready = 1;
        lookup(7'h55);
        check("t6_miss", ifc.rsp_hit, 0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            cfg_clr       = ($urandom_range(0, 49) == 0);
            cfg_we        = ($urandom_range(0, 3) == 0);
            cfg_idx       = IDX_W'($urandom_range(0, NR_KEY - 1));
            cfg_key       = KEY_LEN'($urandom_range(0, 7));
            cfg_data      = $urandom;
            default_out   = $urandom;
            ifc.req_valid = ($urandom_range(0, 2) != 0);
            ifc.req_key   = ($urandom_range(0, 9) == 0) ? KEY_LEN'($urandom) : KEY_LEN'($urandom_range(0, 7));
            ifc.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n = 1;
        set_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
